serial_add_sub: RTL and testbench

Multi-cycle, parametrised adder/subtractor that processes `DIGIT` bits per clock through a chain of full-adder cells. It holds the carry in a register between cycles and produces the result and NZCV-style flags after `WIDTH/DIGIT` cycles. It sits beside the single-cycle ALU as a low-area arithmetic unit for wide operands. It uses a start/busy/done handshake so that a controller can sequence it.

---
 rtl/alu_pkg.sv | 18 +
 rtl/digit_adder.sv | 35 +++
 rtl/full_adder.sv | 17 +
 rtl/serial_add_sub.sv | 120 ++++++++++++
 tb/tb_serial_add_sub.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the arithmetic units.
//   sas_state_t : serial_add_sub sequencer states
//   alu_flags_t : NZCV flag bundle, packed in the order negative, zero, carry_out, overflow
package alu_pkg;

  typedef enum logic {
    SAS_IDLE,
    SAS_RUN
  } sas_state_t;

  typedef struct packed {
    logic negative;
    logic zero;
    logic carry_out;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full_adder cells.
//   i_a, i_b : DIGIT-bit addend digits
//   i_cin    : carry into bit 0
//   o_sum    : DIGIT-bit sum digit
//   o_cout   : carry out of bit DIGIT-1
//   o_cmsb   : carry into bit DIGIT-1 (used for the overflow flag)
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [DIGIT:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar g = 0; g < DIGIT; g++) begin : g_cell
    full_adder u_fa (
      .i_a    (i_a[g]),
      .i_b    (i_b[g]),
      .i_cin  (w_carry[g]),
      .o_sum  (o_sum[g]),
      .o_cout (w_carry[g+1])
    );
  end

  assign o_cout = w_carry[DIGIT];
  assign o_cmsb = w_carry[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
//   i_a, i_b : addend bits
//   i_cin    : carry in
//   o_sum    : sum bit
//   o_cout   : carry out
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor with start/busy/done handshake.
// Processes DIGIT bits per clock; result and NZCV flags appear after
// WIDTH/DIGIT steps and are held until the next completion or reset.
//   clk, reset        : clock, synchronous active-high reset
//   start, sub, a, b  : request, operation select (1 = a-b) and operands
//   busy, done        : operation in progress / one-cycle completion pulse
//   result            : sum or difference
//   negative, zero    : sign of result, result == 0
//   carry_out         : carry out of MSB (1 = no borrow when subtracting)
//   overflow          : two's-complement overflow
module serial_add_sub
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = $clog2(STEPS + 1);

  sas_state_t       r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  alu_flags_t       r_flags;

  logic [DIGIT-1:0] w_sum;
  logic             w_cout;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_sr_next;
  logic             w_last;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .i_a    (r_sa[DIGIT-1:0]),
    .i_b    (r_sb[DIGIT-1:0]),
    .i_cin  (r_c),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_cmsb (w_cmsb)
  );

  // New digit enters at the top; written as shifts so DIGIT == WIDTH needs no special case.
  assign w_sr_next = (r_sr >> DIGIT) | (WIDTH'(w_sum) << (WIDTH - DIGIT));
  assign w_last    = (r_cnt == CW'(STEPS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= SAS_IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_sr     <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        SAS_IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= sub ? ~b : b;
            r_c     <= sub;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SAS_RUN;
          end
        end
        SAS_RUN: begin
          r_sr  <= w_sr_next;
          r_sa  <= r_sa >> DIGIT;
          r_sb  <= r_sb >> DIGIT;
          r_c   <= w_cout;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_result          <= w_sr_next;
            r_flags.negative  <= w_sr_next[WIDTH-1];
            r_flags.zero      <= (w_sr_next == '0);
            r_flags.carry_out <= w_cout;
            r_flags.overflow  <= w_cmsb ^ w_cout;
            r_done            <= 1'b1;
            r_busy            <= 1'b0;
            r_state           <= SAS_IDLE;
          end
        end
        default: r_state <= SAS_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign negative  = r_flags.negative;
  assign zero      = r_flags.zero;
  assign carry_out = r_flags.carry_out;
  assign overflow  = r_flags.overflow;

endmodule

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 8-bit instances: DIGIT = 1, 2, 4
  logic       start8 [3];
  logic       sub8   [3];
  logic [7:0] a8     [3];
  logic [7:0] b8     [3];
  logic       busy8  [3];
  logic       done8  [3];
  logic [7:0] res8   [3];
  logic       n8 [3], z8 [3], c8 [3], v8 [3];

  // 64-bit instances: DIGIT = 1, 8, 64
  logic        start64 [3];
  logic        sub64   [3];
  logic [63:0] a64     [3];
  logic [63:0] b64     [3];
  logic        busy64  [3];
  logic        done64  [3];
  logic [63:0] res64   [3];
  logic        n64 [3], z64 [3], c64 [3], v64 [3];

  for (genvar g = 0; g < 3; g++) begin : g8
    localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    serial_add_sub #(.WIDTH(8), .DIGIT(D)) u_dut (
      .clk(clk), .reset(reset), .start(start8[g]), .sub(sub8[g]),
      .a(a8[g]), .b(b8[g]), .busy(busy8[g]), .done(done8[g]),
      .result(res8[g]), .negative(n8[g]), .zero(z8[g]),
      .carry_out(c8[g]), .overflow(v8[g])
    );
  end

  for (genvar g = 0; g < 3; g++) begin : g64
    localparam int D = (g == 0) ? 1 : (g == 1) ? 8 : 64;
    serial_add_sub #(.WIDTH(64), .DIGIT(D)) u_dut (
      .clk(clk), .reset(reset), .start(start64[g]), .sub(sub64[g]),
      .a(a64[g]), .b(b64[g]), .busy(busy64[g]), .done(done64[g]),
      .result(res64[g]), .negative(n64[g]), .zero(z64[g]),
      .carry_out(c64[g]), .overflow(v64[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;
  int both_hi = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at #1 after an edge; start is sampled at the next edge (E0).
  task automatic go8(input int idx, input logic [7:0] a, input logic [7:0] b, input logic s);
    a8[idx] = a; b8[idx] = b; sub8[idx] = s; start8[idx] = 1'b1;
    @(posedge clk); #1;
    start8[idx] = 1'b0;
  endtask

  task automatic go64(input int idx, input logic [63:0] a, input logic [63:0] b, input logic s);
    a64[idx] = a; b64[idx] = b; sub64[idx] = s; start64[idx] = 1'b1;
    @(posedge clk); #1;
    start64[idx] = 1'b0;
  endtask

  // Returns latency in edges counting E0 as edge 1; bounded.
  task automatic wait8(input int idx, output int lat);
    lat = 1;
    while (done8[idx] !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (busy8[idx] && done8[idx]) both_hi++;
    end
  endtask

  task automatic wait64(input int idx, output int lat);
    lat = 1;
    while (done64[idx] !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (busy64[idx] && done64[idx]) both_hi++;
    end
  endtask

  typedef struct {
    int         idx;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] res;
    logic [3:0] nzcv;
    int         lat;
  } vec8_t;

  vec8_t tv [8];

  initial begin
    int lat;
    int seen;
    logic [63:0] ra, rb, bb, mres;
    logic [64:0] full;
    logic rs, mc, mv;
    int d;

    tv[0] = '{0, 8'h0F, 8'h01, 1'b0, 8'h10, 4'b0000, 9};
    tv[1] = '{0, 8'h10, 8'h01, 1'b1, 8'h0F, 4'b0010, 9};
    tv[2] = '{1, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1001, 5};
    tv[3] = '{1, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0110, 5};
    tv[4] = '{1, 8'h00, 8'h01, 1'b1, 8'hFF, 4'b1000, 5};
    tv[5] = '{2, 8'h05, 8'h05, 1'b1, 8'h00, 4'b0110, 3};
    tv[6] = '{2, 8'h03, 8'h05, 1'b1, 8'hFE, 4'b1000, 3};
    tv[7] = '{2, 8'h80, 8'h01, 1'b1, 8'h7F, 4'b0011, 3};

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start8[i] = 1'b0; sub8[i] = 1'b0; a8[i] = '0; b8[i] = '0;
      start64[i] = 1'b0; sub64[i] = 1'b0; a64[i] = '0; b64[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset_outs8", {busy8[0], done8[0], res8[0], n8[0], z8[0], c8[0], v8[0]}, '0);
    chk("reset_outs64", {busy64[2], done64[2], res64[2], n64[2], z64[2], c64[2], v64[2]}, '0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      go8(tv[i].idx, tv[i].a, tv[i].b, tv[i].sub);
      chk($sformatf("busy_after_start[%0d]", i), busy8[tv[i].idx], 1'b1);
      wait8(tv[i].idx, lat);
      chk($sformatf("latency[%0d]", i), lat, tv[i].lat);
      chk($sformatf("result[%0d]", i), res8[tv[i].idx], tv[i].res);
      chk($sformatf("nzcv[%0d]", i), {n8[tv[i].idx], z8[tv[i].idx], c8[tv[i].idx], v8[tv[i].idx]}, tv[i].nzcv);
      @(posedge clk); #1;
      chk($sformatf("done_one_cycle[%0d]", i), done8[tv[i].idx], 1'b0);
    end

    // Start while busy is ignored
    go8(0, 8'h0F, 8'h01, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    a8[0] = 8'hAA; b8[0] = 8'h11; sub8[0] = 1'b1; start8[0] = 1'b1;
    @(posedge clk); #1;
    start8[0] = 1'b0;
    wait8(0, lat);
    chk("ignored_latency", lat + 3, 9);
    chk("ignored_result", res8[0], 8'h10);
    chk("ignored_nzcv", {n8[0], z8[0], c8[0], v8[0]}, 4'b0000);

    // Start in the done cycle: accepted, previous result holds
    go8(0, 8'h20, 8'h03, 1'b0);
    chk("b2b_busy", busy8[0], 1'b1);
    chk("b2b_done_low", done8[0], 1'b0);
    chk("b2b_hold", res8[0], 8'h10);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_hold_mid", res8[0], 8'h10);
    wait8(0, lat);
    chk("b2b_latency", lat + 4, 9);
    chk("b2b_result", res8[0], 8'h23);

    // Reset mid-operation on 64-bit DIGIT=1
    go64(0, 64'd1, 64'd1, 1'b0);
    wait64(0, lat);
    chk("pre_reset_result", res64[0], 64'd2);
    go64(0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("mid_reset_outs", {busy64[0], done64[0], res64[0], n64[0], z64[0], c64[0], v64[0]}, '0);
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done64[0]) seen++;
    end
    chk("no_done_after_reset", seen, 0);
    go64(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    wait64(0, lat);
    chk("post_reset_latency", lat, 65);
    chk("post_reset_result", res64[0], 64'd0);
    chk("post_reset_nzcv", {n64[0], z64[0], c64[0], v64[0]}, 4'b0110);

    // Reset asserted together with start: reset wins
    a64[1] = 64'd5; b64[1] = 64'd7; sub64[1] = 1'b0; start64[1] = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    start64[1] = 1'b0; reset = 1'b0;
    chk("reset_beats_start", busy64[1], 1'b0);

    // Random against behavioural model
    for (int i = 0; i < 1000; i++) begin
      d  = i % 3;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      bb = rs ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, bb} + {64'd0, rs};
      mres = full[63:0];
      mc = full[64];
      mv = (ra[63] == bb[63]) && (mres[63] != ra[63]);
      go64(d, ra, rb, rs);
      wait64(d, lat);
      chk($sformatf("rand_lat[%0d]", i), lat, (d == 0) ? 65 : (d == 1) ? 9 : 2);
      chk($sformatf("rand_result[%0d]", i), res64[d], mres);
      chk($sformatf("rand_nzcv[%0d]", i), {n64[d], z64[d], c64[d], v64[d]},
          {mres[63], (mres == 64'd0), mc, mv});
    end

    chk("busy_done_exclusive", both_hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
